safecrack_dialer: RTL and testbench

SAFECRACK_DIALER -- requirements
Module: safecrack_dialer

---
 rtl/safecrack_dialer_if.sv | 21 ++
 rtl/safecrack_dialer.sv | 182 ++++++++++++++++++
 tb/tb_safecrack_dialer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/safecrack_dialer_if.sv
// Button/strobe inputs and emulated-press/status outputs of the safecrack dialer.
// The master side drives buttons, start and learn; the slave side is the dialer.
interface safecrack_dialer_if;
    logic [2:0] btn;
    logic       start;
    logic       learn;
    logic [2:0] btn_out;
    logic [2:0] led;
    logic       busy;
    logic       done;

    modport master (
        output btn, start, learn,
        input  btn_out, led, busy, done
    );

    modport slave (
        input  btn, start, learn,
        output btn_out, led, busy, done
    );
endinterface

// File: rtl/safecrack_dialer.sv
// Replays a stored 3-symbol button combination as timed active-low presses.
// Define SAFECRACK_DIALER_LEARN_EN to allow reprogramming the combination from the buttons.
//
// state | meaning
// IDLE  | waiting for start (or learn when enabled)
// PRESS | holding combo[idx] low for STEP_LEN cycles
// GAP   | all buttons released for GAP_LEN cycles
// DONE  | one-cycle completion pulse
// LEARN | capturing three single-button edges into the shadow (LEARN_EN only)
module safecrack_dialer #(
    parameter int STEP_LEN = 50_000_000,
    parameter int GAP_LEN  = 25_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    safecrack_dialer_if.slave bus
);
    localparam int MAX_LEN = (STEP_LEN > GAP_LEN) ? STEP_LEN : GAP_LEN;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
    localparam logic [2:0][1:0] COMBO_RST = {2'd2, 2'd1, 2'd0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
`ifdef SAFECRACK_DIALER_LEARN_EN
        S_LEARN = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [2:0][1:0] combo;
    logic [1:0]      sym;
    logic [2:0]      sym_oh;

`ifdef SAFECRACK_DIALER_LEARN_EN
    logic [2:0][1:0] combo_q, combo_d;
    logic [2:0][1:0] shadow_q, shadow_d;
    logic [1:0]      n_q, n_d;
    logic [2:0]      prev_q;
    logic [2:0]      pressed, edge_v;
    logic            edge_onehot;
    logic [1:0]      edge_idx;

    assign combo       = combo_q;
    assign pressed     = ~bus.btn;
    assign edge_v      = pressed & ~prev_q;
    assign edge_onehot = (edge_v == 3'b001) || (edge_v == 3'b010) || (edge_v == 3'b100);
    assign edge_idx    = edge_v[2] ? 2'd2 : (edge_v[1] ? 2'd1 : 2'd0);
`else
    logic unused_learn_inputs;

    assign combo               = COMBO_RST;
    assign unused_learn_inputs = ^{bus.btn, bus.learn};
`endif

    assign sym    = (idx_q == 2'd0) ? combo[0] : ((idx_q == 2'd1) ? combo[1] : combo[2]);
    assign sym_oh = 3'b001 << sym;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
`ifdef SAFECRACK_DIALER_LEARN_EN
            combo_q  <= COMBO_RST;
            shadow_q <= '0;
            n_q      <= '0;
            prev_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
`ifdef SAFECRACK_DIALER_LEARN_EN
            combo_q  <= combo_d;
            shadow_q <= shadow_d;
            n_q      <= n_d;
            prev_q   <= pressed;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
`ifdef SAFECRACK_DIALER_LEARN_EN
        combo_d  = combo_q;
        shadow_d = shadow_q;
        n_d      = n_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SAFECRACK_DIALER_LEARN_EN
                if (bus.learn) begin
                    state_d = S_LEARN;
                    n_d     = '0;
                end else
`endif
                if (bus.start) begin
                    state_d = S_PRESS;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_PRESS: begin
                if (cnt_q == STEP_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_PRESS;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
`ifdef SAFECRACK_DIALER_LEARN_EN
            S_LEARN: begin
                if (!bus.learn) begin
                    state_d = S_IDLE;
                    n_d     = '0;
                end else if (edge_onehot) begin
                    // third capture commits straight from the shadow plus the new symbol
                    if (n_q == 2'd2) begin
                        combo_d = {edge_idx, shadow_q[1], shadow_q[0]};
                        n_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        shadow_d[n_q[0]] = edge_idx;
                        n_d              = n_q + 2'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.btn_out = 3'b111;
        bus.led     = 3'b000;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state_q)
            S_PRESS: begin
                bus.btn_out = ~sym_oh;
                bus.led     = sym_oh;
                bus.busy    = 1'b1;
            end
            S_GAP:  bus.busy = 1'b1;
            S_DONE: bus.done = 1'b1;
`ifdef SAFECRACK_DIALER_LEARN_EN
            S_LEARN: bus.led = {1'b0, n_q == 2'd2, n_q != 2'd0};
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_safecrack_dialer.sv
// Directed bench for safecrack_dialer with STEP_LEN=4, GAP_LEN=2; expected output
// cycles are queued when start is driven and popped as the playback runs.
module tb_safecrack_dialer;
    localparam int STEP_LEN = 4;
    localparam int GAP_LEN  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    safecrack_dialer_if bus ();

    safecrack_dialer #(.STEP_LEN(STEP_LEN), .GAP_LEN(GAP_LEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [2:0] btn_out;
        logic [2:0] led;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_combo [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, " btn_out"}, 8'(bus.btn_out), 8'(e.btn_out));
        chk({tag, " led"},     8'(bus.led),     8'(e.led));
        chk({tag, " busy"},    8'(bus.busy),    8'(e.busy));
        chk({tag, " done"},    8'(bus.done),    8'(e.done));
    endtask

    task automatic check_idle(input string tag);
        exp_t e;
        e = '{btn_out: 3'b111, led: 3'b000, busy: 1'b0, done: 1'b0};
        check_out(tag, e);
    endtask

    task automatic push_play();
        logic [2:0] oh;
        for (int s = 0; s < 3; s++) begin
            oh = 3'b001 << exp_combo[s];
            for (int c = 0; c < STEP_LEN; c++)
                sb_q.push_back('{btn_out: ~oh, led: oh, busy: 1'b1, done: 1'b0});
            for (int c = 0; c < GAP_LEN; c++)
                sb_q.push_back('{btn_out: 3'b111, led: 3'b000, busy: 1'b1, done: 1'b0});
        end
        sb_q.push_back('{btn_out: 3'b111, led: 3'b000, busy: 1'b0, done: 1'b1});
        sb_q.push_back('{btn_out: 3'b111, led: 3'b000, busy: 1'b0, done: 1'b0});
    endtask

    // Pulses start, then checks one queued cycle per negedge; start is re-pulsed
    // after entry restart_at, and checking stops after stop_after entries.
    task automatic run_play(input string tag, input int restart_at, input int stop_after);
        int   i;
        exp_t e;
        i = 0;
        @(negedge clk) bus.start = 1'b1;
        push_play();
        @(negedge clk) bus.start = 1'b0;
        while (sb_q.size() > 0 && i < stop_after) begin
            e = sb_q.pop_front();
            check_out($sformatf("%s[%0d]", tag, i), e);
            bus.start = (i == restart_at);
            i++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        sb_q.delete();
    endtask

    task automatic press(input logic [2:0] mask);
        @(negedge clk) bus.btn = ~mask;
        @(negedge clk) bus.btn = 3'b111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn   = 3'b111;
        bus.start = 1'b0;
        bus.learn = 1'b0;
        exp_combo = '{0, 1, 2};

        #2;
        check_idle("reset");
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_play("play", -1, 1000);
        run_play("restart", 4, 1000);

`ifdef SAFECRACK_DIALER_LEARN_EN
        @(negedge clk) bus.learn = 1'b1;
        press(3'b011);
        chk("learn_multi led", 8'(bus.led), 8'(3'b000));
        press(3'b100);
        chk("learn_abort1 led", 8'(bus.led), 8'(3'b001));
        press(3'b001);
        chk("learn_abort2 led", 8'(bus.led), 8'(3'b011));
        @(negedge clk) bus.learn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_idle($sformatf("learn_abort_idle[%0d]", k));
        end
        run_play("after_abort", -1, 1000);

        @(negedge clk) bus.learn = 1'b1;
        press(3'b100);
        chk("learn1 led", 8'(bus.led), 8'(3'b001));
        chk("learn1 busy", 8'(bus.busy), 8'(1'b0));
        press(3'b001);
        chk("learn2 led", 8'(bus.led), 8'(3'b011));
        @(negedge clk) bus.btn = 3'b101;
        @(negedge clk);
        chk("learn_done done", 8'(bus.done), 8'(1'b1));
        chk("learn_done busy", 8'(bus.busy), 8'(1'b0));
        chk("learn_done led", 8'(bus.led), 8'(3'b000));
        bus.btn   = 3'b111;
        bus.learn = 1'b0;
        @(negedge clk);
        check_idle("learn_after");
        exp_combo = '{2, 0, 1};
        run_play("learned", -1, 1000);
`else
        @(negedge clk) bus.learn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] m;
            m = 3'b001 << (k % 3);
            press(m);
            check_idle($sformatf("learn_ignored[%0d]", k));
        end
        bus.learn = 1'b0;
        run_play("no_learn_play", -1, 1000);
`endif

        run_play("abort", -1, 8);
        rstn = 1'b0;
        #1;
        check_idle("async_reset");
        exp_combo = '{0, 1, 2};
        @(negedge clk) rstn = 1'b1;
        run_play("after_reset", -1, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
